// File: rtl/sample_pkg.sv
// sample_pkg: shared constants, state encoding and config-clamp helpers for
// the acquisition window controller (sample_window_ctrl, sample_stats_acc).
package sample_pkg;

  localparam int DW = 13;       // sample width (signed)
  localparam int CW = 10;       // sample-count width
  localparam int PW = 19;       // period-counter width
  localparam int SW = DW + CW;  // accumulator width, wide enough for 2^CW-1 samples

  localparam logic [PW-1:0] PERIOD_50US = 19'd4999;
  localparam logic [PW-1:0] PERIOD_MIN  = 19'd2;
  localparam logic [PW-1:0] PERIOD_ONE  = 19'd1;
  localparam logic [CW-1:0] COUNT_ONE   = 10'd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_e;

  // A period below 2 would make the capture compare (period-1) degenerate.
  function automatic logic [PW-1:0] clamp_period(input logic [PW-1:0] p);
    if (p < PERIOD_MIN) begin
      return PERIOD_MIN;
    end else begin
      return p;
    end
  endfunction

  // A zero-length window is run as a single-sample window.
  function automatic logic [CW-1:0] clamp_count(input logic [CW-1:0] c);
    if (c == {CW{1'b0}}) begin
      return COUNT_ONE;
    end else begin
      return c;
    end
  endfunction

endpackage

// File: rtl/sample_stats_acc.sv
// sample_stats_acc: running signed sum / max / min over the captured samples.
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset (all outputs 0)
//   i_clear         load sum=0, max=most negative, min=most positive
//   i_en            fold i_sample into the statistics
//   i_sample        signed sample (DW)
//   o_sum           signed sum (SW), o_max / o_min signed extremes (DW)
module sample_stats_acc
  import sample_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clear,
  input  logic          i_en,
  input  logic [DW-1:0] i_sample,
  output logic [SW-1:0] o_sum,
  output logic [DW-1:0] o_max,
  output logic [DW-1:0] o_min
);

  logic [SW-1:0] r_sum;
  logic [DW-1:0] r_max;
  logic [DW-1:0] r_min;
  logic [SW-1:0] w_sample_ext;

  // Sign-extend the sample to accumulator width.
  always_comb begin
    w_sample_ext = {{CW{i_sample[DW-1]}}, i_sample};
  end

  // Statistics registers: clear has priority over accumulate.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum <= {SW{1'b0}};
      r_max <= {DW{1'b0}};
      r_min <= {DW{1'b0}};
    end else if (i_clear) begin
      r_sum <= {SW{1'b0}};
      r_max <= {1'b1, {(DW-1){1'b0}}};
      r_min <= {1'b0, {(DW-1){1'b1}}};
    end else if (i_en) begin
      r_sum <= r_sum + w_sample_ext;
      if ($signed(i_sample) > $signed(r_max)) begin
        r_max <= i_sample;
      end else begin
        r_max <= r_max;
      end
      if ($signed(i_sample) < $signed(r_min)) begin
        r_min <= i_sample;
      end else begin
        r_min <= r_min;
      end
    end else begin
      r_sum <= r_sum;
      r_max <= r_max;
      r_min <= r_min;
    end
  end

  assign o_sum = r_sum;
  assign o_max = r_max;
  assign o_min = r_min;

endmodule

// File: rtl/sample_window_ctrl.sv
// sample_window_ctrl: runs one software-started acquisition window. Captures
// i_adc_data every latched period, hands samples out through a one-entry
// valid/ready buffer and accumulates sum/max/min over the window.
// Ports:
//   i_clk, i_rst_n              clock, async active-low reset
//   i_start, i_abort            one-cycle command pulses (abort dominates)
//   i_cfg_period, i_cfg_count   latched at an accepted start
//   i_adc_data                  live signed sample
//   o_smp_data, o_smp_valid,
//   i_smp_ready                 downstream handshake
//   o_busy, o_done, o_overrun   window status
//   o_sum, o_max_val, o_min_val window statistics (valid when o_done)
module sample_window_ctrl
  import sample_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [PW-1:0] i_cfg_period,
  input  logic [CW-1:0] i_cfg_count,
  input  logic [DW-1:0] i_adc_data,
  output logic [DW-1:0] o_smp_data,
  output logic          o_smp_valid,
  input  logic          i_smp_ready,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_overrun,
  output logic [SW-1:0] o_sum,
  output logic [DW-1:0] o_max_val,
  output logic [DW-1:0] o_min_val
);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [PW-1:0] r_period;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_per_cnt;
  logic [CW-1:0] r_smp_cnt;
  logic [DW-1:0] r_smp_data;
  logic          r_smp_valid;
  logic          r_overrun;
  logic          r_busy;
  logic          r_done;
  logic          w_start_acc;
  logic          w_capture;
  logic          w_last;

  // Command qualification and capture-edge detection; abort masks both.
  always_comb begin
    w_start_acc = i_start && !i_abort && ((r_state == IDLE) || (r_state == DONE));
    w_capture   = (r_state == CAPTURE) && !i_abort && (r_per_cnt == (r_period - PERIOD_ONE));
    w_last      = w_capture && (r_smp_cnt == (r_count - COUNT_ONE));
  end

  // Next-state logic. DRAIN exits on the edge that empties the buffer.
  always_comb begin
    w_state_nxt = r_state;
    if (i_abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = w_start_acc ? CAPTURE : IDLE;
        CAPTURE: w_state_nxt = w_last ? DRAIN : CAPTURE;
        DRAIN:   w_state_nxt = (!r_smp_valid || i_smp_ready) ? DONE : DRAIN;
        DONE:    w_state_nxt = w_start_acc ? CAPTURE : DONE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State register with registered busy/done decoded from the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == CAPTURE) || (w_state_nxt == DRAIN);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  // Latched config plus period and sample counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_period  <= {PW{1'b0}};
      r_count   <= {CW{1'b0}};
      r_per_cnt <= {PW{1'b0}};
      r_smp_cnt <= {CW{1'b0}};
    end else if (w_start_acc) begin
      r_period  <= clamp_period(i_cfg_period);
      r_count   <= clamp_count(i_cfg_count);
      r_per_cnt <= {PW{1'b0}};
      r_smp_cnt <= {CW{1'b0}};
    end else if (w_capture) begin
      r_per_cnt <= {PW{1'b0}};
      r_smp_cnt <= r_smp_cnt + COUNT_ONE;
    end else if ((r_state == CAPTURE) && !i_abort) begin
      r_per_cnt <= r_per_cnt + PERIOD_ONE;
    end else begin
      r_per_cnt <= r_per_cnt;
    end
  end

  // One-entry output buffer; a capture into a stalled full buffer is dropped
  // and flagged, but the sample still reaches the statistics.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_smp_data  <= {DW{1'b0}};
      r_smp_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (i_abort) begin
      r_smp_valid <= 1'b0;
    end else if (w_start_acc) begin
      r_overrun   <= 1'b0;
    end else if (w_capture) begin
      if (!r_smp_valid || i_smp_ready) begin
        r_smp_data  <= i_adc_data;
        r_smp_valid <= 1'b1;
      end else begin
        r_overrun   <= 1'b1;
      end
    end else if (r_smp_valid && i_smp_ready) begin
      r_smp_valid <= 1'b0;
    end else begin
      r_smp_valid <= r_smp_valid;
    end
  end

  sample_stats_acc u_stats (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (w_start_acc),
    .i_en     (w_capture),
    .i_sample (i_adc_data),
    .o_sum    (o_sum),
    .o_max    (o_max_val),
    .o_min    (o_min_val)
  );

  assign o_smp_data  = r_smp_data;
  assign o_smp_valid = r_smp_valid;
  assign o_overrun   = r_overrun;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule
